pipeline_mips32: RTL and testbench

//  Five-stage in-order MIPS32-subset core: IF, ID, EX, MEM, WB. Self-contained:

---
 rtl/pipeline_mips32.sv | 110 +++++++++++
 tb/tb_pipeline_mips32.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipeline_mips32.sv
// pipeline_mips32: five-stage in-order MIPS32-subset core with internal register file and unified memory
module pipeline_mips32 #(
    parameter int MEM_WORDS = 1024
) (
    input logic clk,
    input logic rst
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_AND = 6'd2, OP_OR = 6'd3, OP_SLT = 6'd4,
        OP_MUL = 6'd5, OP_LW = 6'd8, OP_SW = 6'd9, OP_ADDI = 6'd10, OP_SUBI = 6'd11, OP_SLTI = 6'd12,
        OP_BNEQZ = 6'd13, OP_BEQZ = 6'd14, OP_NOP = 6'd62, OP_HLT = 6'd63;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] rf [32];
    logic [31:0] pc;
    logic        halted;
    logic        taken_branch;

    logic [31:0] ifid_ir, ifid_npc;
    logic [5:0]  idex_op;
    logic [4:0]  idex_dst;
    logic [31:0] idex_npc, idex_a, idex_b, idex_imm;
    logic [5:0]  exmem_op;
    logic [4:0]  exmem_dst;
    logic [31:0] exmem_alu, exmem_b;
    logic        exmem_cond;
    logic [5:0]  memwb_op;

    logic        stall, wb_en, is_rr, ex_cond;
    logic [4:0]  rs, rt;
    logic [31:0] lmd, wb_val, ex_alu, fetch_addr, rd_a, rd_b;

    // HLT in WB freezes the machine; the result leaving MEM is written through to the ID read
    assign stall        = halted || memwb_op == OP_HLT;
    assign lmd          = mem[exmem_alu[AW-1:0]];
    assign wb_en        = !stall && exmem_dst != 5'd0 && (exmem_op <= OP_MUL || exmem_op == OP_LW ||
                          (exmem_op >= OP_ADDI && exmem_op <= OP_SLTI));
    assign wb_val       = exmem_op == OP_LW ? lmd : exmem_alu;
    assign taken_branch = !stall && exmem_cond;
    assign fetch_addr   = taken_branch ? exmem_alu : pc;
    assign rs           = ifid_ir[25:21];
    assign rt           = ifid_ir[20:16];
    assign is_rr        = ifid_ir[31:26] <= OP_MUL;
    assign rd_a         = rs == 5'd0 ? '0 : (wb_en && exmem_dst == rs) ? wb_val : rf[rs];
    assign rd_b         = rt == 5'd0 ? '0 : (wb_en && exmem_dst == rt) ? wb_val : rf[rt];
    assign ex_cond      = (idex_op == OP_BNEQZ && idex_a != '0) || (idex_op == OP_BEQZ && idex_a == '0);

    // ALU, effective address and branch target
    always_comb begin
        case (idex_op)
            OP_ADD:                ex_alu = idex_a + idex_b;
            OP_SUB:                ex_alu = idex_a - idex_b;
            OP_AND:                ex_alu = idex_a & idex_b;
            OP_OR:                 ex_alu = idex_a | idex_b;
            OP_SLT:                ex_alu = {31'd0, $signed(idex_a) < $signed(idex_b)};
            OP_MUL:                ex_alu = idex_a * idex_b;
            OP_ADDI, OP_LW, OP_SW: ex_alu = idex_a + idex_imm;
            OP_SUBI:               ex_alu = idex_a - idex_imm;
            OP_SLTI:               ex_alu = {31'd0, $signed(idex_a) < $signed(idex_imm)};
            OP_BNEQZ, OP_BEQZ:     ex_alu = idex_npc + idex_imm;
            default:               ex_alu = '0;
        endcase
    end

    // Pipeline advance; a taken branch refetches from the target and bubbles the two younger slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= '0;
            halted     <= 1'b0;
            ifid_ir    <= {OP_NOP, 26'd0};
            ifid_npc   <= '0;
            idex_op    <= OP_NOP;
            idex_dst   <= '0;
            idex_npc   <= '0;
            idex_a     <= '0;
            idex_b     <= '0;
            idex_imm   <= '0;
            exmem_op   <= OP_NOP;
            exmem_dst  <= '0;
            exmem_alu  <= '0;
            exmem_b    <= '0;
            exmem_cond <= 1'b0;
            memwb_op   <= OP_NOP;
        end else if (stall) begin
            halted <= 1'b1;
        end else begin
            pc         <= fetch_addr + 32'd1;
            ifid_ir    <= mem[fetch_addr[AW-1:0]];
            ifid_npc   <= fetch_addr + 32'd1;
            idex_op    <= taken_branch ? OP_NOP : ifid_ir[31:26];
            idex_dst   <= is_rr ? ifid_ir[15:11] : rt;
            idex_npc   <= ifid_npc;
            idex_a     <= rd_a;
            idex_b     <= rd_b;
            idex_imm   <= {{16{ifid_ir[15]}}, ifid_ir[15:0]};
            exmem_op   <= taken_branch ? OP_NOP : idex_op;
            exmem_dst  <= idex_dst;
            exmem_alu  <= ex_alu;
            exmem_b    <= idex_b;
            exmem_cond <= !taken_branch && ex_cond;
            memwb_op   <= exmem_op;
        end
    end

    // Register write-back and stores; memories are never reset
    always_ff @(posedge clk) begin
        if (wb_en) rf[exmem_dst] <= wb_val;
        if (!stall && exmem_op == OP_SW) mem[exmem_alu[AW-1:0]] <= exmem_b;
    end
endmodule

// File: tb/tb_pipeline_mips32.sv
// tb_pipeline_mips32: directed programs with hand-computed results for pipeline_mips32
module tb_pipeline_mips32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] p[$];
    localparam logic [31:0] DUMMY = 32'h0e94a000, HLT = 32'hfc000000;

    pipeline_mips32 #(.MEM_WORDS(1024)) dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input int op, input int rs, input int rt, input int rd);
        return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] ri(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    task automatic start_test();
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 1024; i++) dut.mem[i] = 32'h0;
        for (int i = 0; i < 32; i++) dut.rf[i] = i;
        for (int i = 0; i < p.size(); i++) dut.mem[i] = p[i];
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string tag, input int max);
        int n = 0;
        while (!dut.halted && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_halted"}, 32'(dut.halted), 32'd1);
    endtask

    initial begin
        // factorial of Mem[200], also used for the reset-state and mid-loop reset checks
        p = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000, 32'h14431000,
              32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffc, 32'hfc000000};
        start_test();
        dut.mem[200] = 32'd7;
        chk("rst_pc", dut.pc, 32'd0);
        chk("rst_halted", 32'(dut.halted), 32'd0);
        chk("rst_taken", 32'(dut.taken_branch), 32'd0);
        run_to_halt("fact", 400);
        chk("fact_r2", dut.rf[2], 32'd5040);
        chk("fact_r3", dut.rf[3], 32'd0);
        chk("fact_m196", dut.mem[196], 32'd5040);
        chk("fact_m200", dut.mem[200], 32'd7);
        chk("fact_pc", dut.pc, 32'd14);
        repeat (5) @(posedge clk);
        #1;
        chk("fact_pc_frozen", dut.pc, 32'd14);
        chk("fact_r2_frozen", dut.rf[2], 32'd5040);

        // async reset in the second loop iteration
        start_test();
        dut.mem[200] = 32'd7;
        repeat (13) @(posedge clk);
        #1;
        chk("mid_r2", dut.rf[2], 32'd7);
        chk("mid_r3", dut.rf[3], 32'd6);
        chk("mid_pc", dut.pc, 32'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("async_pc", dut.pc, 32'd0);
        chk("async_halted", 32'(dut.halted), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("held_r2", dut.rf[2], 32'd7);
        chk("held_r3", dut.rf[3], 32'd6);
        chk("held_pc", dut.pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_to_halt("rerun", 400);
        chk("rerun_r2", dut.rf[2], 32'd5040);
        chk("rerun_m200", dut.mem[200], 32'd7);

        // ALU operations and R0 write suppression
        p = '{ri(10, 0, 1, 10), ri(10, 0, 2, 20), DUMMY, DUMMY, rr(0, 1, 2, 3), rr(1, 1, 2, 4),
              rr(4, 1, 2, 5), rr(2, 1, 2, 6), rr(3, 1, 2, 7), ri(12, 4, 8, -5), ri(11, 1, 9, 3),
              ri(10, 1, 0, 5), DUMMY, ri(10, 0, 10, 1), HLT};
        start_test();
        run_to_halt("alu", 200);
        chk("alu_add", dut.rf[3], 32'd30);
        chk("alu_sub", dut.rf[4], 32'hfffffff6);
        chk("alu_slt", dut.rf[5], 32'd1);
        chk("alu_and", dut.rf[6], 32'd0);
        chk("alu_or", dut.rf[7], 32'd30);
        chk("alu_slti", dut.rf[8], 32'd1);
        chk("alu_subi", dut.rf[9], 32'd7);
        chk("alu_r0_read", dut.rf[10], 32'd1);
        chk("alu_r0_kept", dut.rf[0], 32'd0);

        // taken BEQZ squashes the two younger slots, including a HLT
        p = '{ri(14, 0, 0, 4), ri(10, 0, 7, 99), HLT, ri(10, 0, 8, 55), ri(10, 0, 8, 56),
              ri(10, 0, 9, 77), HLT};
        start_test();
        repeat (3) @(posedge clk);
        #1;
        chk("br_taken", 32'(dut.taken_branch), 32'd1);
        @(posedge clk);
        #1;
        chk("br_taken_drop", 32'(dut.taken_branch), 32'd0);
        chk("br_pc", dut.pc, 32'd6);
        repeat (4) @(posedge clk);
        #1;
        chk("br_shadow_hlt", 32'(dut.halted), 32'd0);
        run_to_halt("br", 100);
        chk("br_r7", dut.rf[7], 32'd7);
        chk("br_r8", dut.rf[8], 32'd8);
        chk("br_r9", dut.rf[9], 32'd77);

        // not-taken BNEQZ falls through
        p = '{ri(13, 0, 0, 10), ri(10, 0, 11, 111), ri(10, 0, 12, 122), HLT};
        start_test();
        repeat (3) @(posedge clk);
        #1;
        chk("nt_taken", 32'(dut.taken_branch), 32'd0);
        run_to_halt("nt", 100);
        chk("nt_r11", dut.rf[11], 32'd111);
        chk("nt_r12", dut.rf[12], 32'd122);
        chk("nt_pc", dut.pc, 32'd7);

        // load with one slot gap feeding MUL (wrapping), then store of the product
        p = '{ri(8, 0, 3, 100), DUMMY, rr(5, 3, 5, 4), DUMMY, ri(9, 0, 4, 101), HLT};
        start_test();
        dut.mem[100] = 32'h80000001;
        run_to_halt("wt", 100);
        chk("wt_r3", dut.rf[3], 32'h80000001);
        chk("wt_mul", dut.rf[4], 32'h80000005);
        chk("wt_store", dut.mem[101], 32'h80000005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
